// File: rtl/frv_rng_prng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frv_rng_prng_pkg
// Brief    : Shared op/status encodings, FSM states and health helper for
//            the randomness-source block.
// Revision : 1.0
// ============================================================================
package frv_rng_prng_pkg;

  localparam int unsigned c_lfsr_w = 32;

  localparam logic [2:0] c_op_seed = 3'b001;
  localparam logic [2:0] c_op_samp = 3'b010;
  localparam logic [2:0] c_op_test = 3'b100;

  localparam logic [2:0] c_status_no_init   = 3'b000;
  localparam logic [2:0] c_status_unhealthy = 3'b001;
  localparam logic [2:0] c_status_healthy   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RSP  = 2'd2
  } rng_state_e;

  // Health reported to the core: unseeded beats exhausted.
  function automatic logic [2:0] health_status(input logic seeded, input logic exhausted);
    if (!seeded) begin
      return c_status_no_init;
    end else if (exhausted) begin
      return c_status_unhealthy;
    end
    return c_status_healthy;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frv_rng_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : frv_rng_lfsr_step
// Brief    : One Galois LFSR step (right shift, feedback mask on bit 0).
// Revision : 1.0
// ============================================================================
module frv_rng_lfsr_step
  import frv_rng_prng_pkg::*;
#(
  parameter logic [c_lfsr_w-1:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic [c_lfsr_w-1:0] i_lfsr,
  output logic [c_lfsr_w-1:0] o_lfsr
);

  logic [c_lfsr_w-1:0] w_shifted;

  assign w_shifted = i_lfsr >> 1;
  assign o_lfsr    = i_lfsr[0] ? (w_shifted ^ LFSR_TAPS) : w_shifted;

endmodule
`default_nettype wire

// File: rtl/frv_rng_prng.sv
`default_nettype none
// ============================================================================
// Module   : frv_rng_prng
// Brief    : LFSR-based randomness source serving SEED/SAMP/TEST requests
//            with a single-outstanding valid/ready request/response pair.
// Revision : 1.0
// ============================================================================
module frv_rng_prng
  import frv_rng_prng_pkg::*;
#(
  parameter logic [31:0] LFSR_RESET   = 32'h6789_ABCD,
  parameter logic [31:0] LFSR_TAPS    = 32'h8020_0003,
  parameter int unsigned SEED_CYCLES  = 8,
  parameter int unsigned RESEED_LIMIT = 1024,
  parameter bit          FREE_RUN     = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        rng_req_valid,
  input  logic [2:0]  rng_req_op,
  input  logic [31:0] rng_req_data,
  output logic        rng_req_ready,
  output logic        rng_rsp_valid,
  output logic [2:0]  rng_rsp_status,
  output logic [31:0] rng_rsp_data,
  input  logic        rng_rsp_ready
);

  localparam int unsigned        c_cnt_w    = $clog2(RESEED_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(RESEED_LIMIT);
  localparam logic [7:0]         c_mix_last = 8'(SEED_CYCLES - 1);

  rng_state_e          r_state;
  rng_state_e          w_state_nxt;
  logic [31:0]         r_lfsr;
  logic [31:0]         w_lfsr_nxt;
  logic [31:0]         w_lfsr_step;
  logic [31:0]         w_seed_mix;
  logic                r_seeded;
  logic                w_seeded_nxt;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_cnt_w-1:0]  w_count_nxt;
  logic [c_cnt_w-1:0]  w_count_inc;
  logic [7:0]          r_mix;
  logic [7:0]          w_mix_nxt;
  logic [31:0]         r_rsp_data;
  logic [31:0]         w_rsp_data_nxt;
  logic [2:0]          r_rsp_status;
  logic [2:0]          w_rsp_status_nxt;
  logic                w_req_fire;
  logic                w_exhausted;
  logic                w_idle_step;

  frv_rng_lfsr_step #(
    .LFSR_TAPS (LFSR_TAPS)
  ) u_step (
    .i_lfsr (r_lfsr),
    .o_lfsr (w_lfsr_step)
  );

  // Whether the LFSR keeps advancing while no SAMP/mixing is in progress.
  generate
    if (FREE_RUN) begin : g_free_run
      assign w_idle_step = 1'b1;
    end else begin : g_gated_step
      assign w_idle_step = 1'b0;
    end
  endgenerate

  assign rng_req_ready  = (r_state == ST_IDLE);
  assign rng_rsp_valid  = (r_state == ST_RSP);
  assign rng_rsp_status = r_rsp_status;
  assign rng_rsp_data   = r_rsp_data;

  assign w_req_fire  = rng_req_valid && (r_state == ST_IDLE);
  assign w_exhausted = (r_count >= c_cnt_max);
  assign w_count_inc = w_exhausted ? c_cnt_max : (r_count + 1'b1);
  assign w_seed_mix  = r_lfsr ^ rng_req_data;

  always_comb begin
    w_state_nxt      = r_state;
    w_lfsr_nxt       = w_idle_step ? w_lfsr_step : r_lfsr;
    w_seeded_nxt     = r_seeded;
    w_count_nxt      = r_count;
    w_mix_nxt        = r_mix;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_status_nxt = r_rsp_status;

    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) begin
          case (rng_req_op)
            c_op_samp: begin
              w_rsp_data_nxt   = r_lfsr;
              w_rsp_status_nxt = health_status(r_seeded, w_exhausted);
              w_lfsr_nxt       = w_lfsr_step;
              w_count_nxt      = w_count_inc;
              w_state_nxt      = ST_RSP;
            end
            c_op_seed: begin
              // An all-zero Galois LFSR is a lock-up state, so fall back to the reset value.
              w_lfsr_nxt   = (w_seed_mix == '0) ? LFSR_RESET : w_seed_mix;
              w_seeded_nxt = 1'b1;
              w_count_nxt  = '0;
              w_mix_nxt    = '0;
              w_state_nxt  = ST_BUSY;
            end
            default: begin
              w_rsp_data_nxt   = '0;
              w_rsp_status_nxt = health_status(r_seeded, w_exhausted);
              w_state_nxt      = ST_RSP;
            end
          endcase
        end
      end
      ST_BUSY: begin
        w_lfsr_nxt = w_lfsr_step;
        w_mix_nxt  = r_mix + 8'd1;
        if (r_mix == c_mix_last) begin
          w_rsp_data_nxt   = '0;
          w_rsp_status_nxt = health_status(r_seeded, w_exhausted);
          w_state_nxt      = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rng_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= LFSR_RESET;
      r_seeded     <= 1'b0;
      r_count      <= '0;
      r_mix        <= '0;
      r_rsp_data   <= '0;
      r_rsp_status <= c_status_no_init;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_seeded     <= w_seeded_nxt;
      r_count      <= w_count_nxt;
      r_mix        <= w_mix_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_status <= w_rsp_status_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frv_rng_prng.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_rng_prng
// Brief    : Directed bench for frv_rng_prng: gated-step and free-running builds.
// Revision : 1.0
// ============================================================================
module tb_frv_rng_prng;

  localparam logic [31:0] c_reset = 32'h6789_ABCD;
  localparam logic [31:0] c_taps  = 32'h8020_0003;
  localparam logic [2:0]  c_seed  = 3'b001;
  localparam logic [2:0]  c_samp  = 3'b010;
  localparam logic [2:0]  c_test  = 3'b100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_data = 32'h0;
  logic        rsp_ready = 1'b1;

  logic        a_req_ready, a_rsp_valid, f_req_ready, f_rsp_valid;
  logic [2:0]  a_rsp_status, f_rsp_status;
  logic [31:0] a_rsp_data, f_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  int          t_lat;
  logic [31:0] t_ad, t_fd;
  logic [2:0]  t_as, t_fs;

  always #5 clk = ~clk;

  frv_rng_prng #(
    .LFSR_RESET   (c_reset),
    .LFSR_TAPS    (c_taps),
    .SEED_CYCLES  (8),
    .RESEED_LIMIT (4),
    .FREE_RUN     (1'b0)
  ) dut_a (
    .g_clk          (clk),
    .g_resetn       (resetn),
    .rng_req_valid  (req_valid),
    .rng_req_op     (req_op),
    .rng_req_data   (req_data),
    .rng_req_ready  (a_req_ready),
    .rng_rsp_valid  (a_rsp_valid),
    .rng_rsp_status (a_rsp_status),
    .rng_rsp_data   (a_rsp_data),
    .rng_rsp_ready  (rsp_ready)
  );

  frv_rng_prng dut_f (
    .g_clk          (clk),
    .g_resetn       (resetn),
    .rng_req_valid  (req_valid),
    .rng_req_op     (req_op),
    .rng_req_data   (req_data),
    .rng_req_ready  (f_req_ready),
    .rng_rsp_valid  (f_rsp_valid),
    .rng_rsp_status (f_rsp_status),
    .rng_rsp_data   (f_rsp_data),
    .rng_rsp_ready  (rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step_n(input logic [31:0] v, input int n);
    logic [31:0] x;
    x = v;
    for (int k = 0; k < n; k++) begin
      x = x[0] ? ((x >> 1) ^ c_taps) : (x >> 1);
    end
    return x;
  endfunction

  // Leaves the bench at posedge+1 with both DUTs freshly reset and idle.
  task automatic do_reset();
    resetn = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // One full request/response with rsp_ready held high; captures the response.
  task automatic transact(input string tag, input logic [2:0] op, input logic [31:0] d);
    int exp_lat;
    exp_lat = (op == c_seed) ? 9 : 1;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_data  = 32'h0;
    t_lat = 1;
    while (!a_rsp_valid && t_lat < 40) begin
      @(posedge clk); #1;
      t_lat++;
    end
    check({tag, "_lat"}, t_lat, exp_lat);
    check({tag, "_fvalid"}, {31'h0, f_rsp_valid}, 32'h1);
    t_ad = a_rsp_data;
    t_as = a_rsp_status;
    t_fd = f_rsp_data;
    t_fs = f_rsp_status;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_req_ready", {31'h0, a_req_ready}, 32'h1);
    check("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("rst_status", {29'h0, a_rsp_status}, 32'h0);
    check("rst_data", a_rsp_data, 32'h0);
    check("rst_f_req_ready", {31'h0, f_req_ready}, 32'h1);

    // Unseeded samples
    transact("samp1", c_samp, 32'h0);
    check("samp1_data", t_ad, 32'h6789_ABCD);
    check("samp1_status", {29'h0, t_as}, 32'h0);
    check("samp1_fdata", t_fd, 32'h6789_ABCD);
    transact("samp2", c_samp, 32'h0);
    check("samp2_data", t_ad, 32'hB3E4_D5E5);
    check("samp2_fdata", t_fd, 32'hD9D2_6AF1);
    check("samp2_status", {29'h0, t_as}, 32'h0);

    // TEST / SEED health transitions
    do_reset();
    transact("test0", c_test, 32'h0);
    check("test0_status", {29'h0, t_as}, 32'h0);
    check("test0_data", t_ad, 32'h0);
    transact("seed0", c_seed, 32'hDEAD_BEEF);
    check("seed0_status", {29'h0, t_as}, 32'h4);
    check("seed0_data", t_ad, 32'h0);
    transact("test1", c_test, 32'h0);
    check("test1_status", {29'h0, t_as}, 32'h4);
    check("test1_fstatus", {29'h0, t_fs}, 32'h4);

    // Seed that would zero the LFSR
    do_reset();
    transact("seedz", c_seed, c_reset);
    check("seedz_status", {29'h0, t_as}, 32'h4);
    transact("sampz", c_samp, 32'h0);
    check("sampz_data", t_ad, step_n(c_reset, 8));
    check("sampz_nonzero", {31'h0, (t_ad != 32'h0)}, 32'h1);
    check("sampz_fdata", t_fd, step_n(c_reset, 9));

    // Health counter saturation and reseed
    do_reset();
    transact("seedh", c_seed, 32'h1234_5678);
    for (int i = 1; i <= 5; i++) begin
      transact($sformatf("samph%0d", i), c_samp, 32'h0);
      check($sformatf("samph%0d_status", i), {29'h0, t_as}, (i == 5) ? 32'h1 : 32'h4);
    end
    check("samph5_fstatus", {29'h0, t_fs}, 32'h4);
    transact("reseed", c_seed, 32'h0BAD_F00D);
    check("reseed_status", {29'h0, t_as}, 32'h4);
    transact("samprs", c_samp, 32'h0);
    check("samprs_status", {29'h0, t_as}, 32'h4);

    // Response back-pressure with a pending request
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = c_samp;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("hold%0d_valid", i), {31'h0, a_rsp_valid}, 32'h1);
      check($sformatf("hold%0d_ready", i), {31'h0, a_req_ready}, 32'h0);
      check($sformatf("hold%0d_data", i), a_rsp_data, c_reset);
      check($sformatf("hold%0d_status", i), {29'h0, a_rsp_status}, 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    check("release_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("release_ready", {31'h0, a_req_ready}, 32'h1);
    transact("samp_after", c_samp, 32'h0);
    check("samp_after_data", t_ad, 32'hB3E4_D5E5);

    // Reset while mixing, then illegal ops
    do_reset();
    req_valid = 1'b1;
    req_op    = c_seed;
    req_data  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_data  = 32'h0;
    check("busy_ready", {31'h0, a_req_ready}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_valid", {31'h0, a_rsp_valid}, 32'h0);
    check("midrst_ready", {31'h0, a_req_ready}, 32'h1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("midrst_quiet", {31'h0, a_rsp_valid}, 32'h0);
    transact("test_rst", c_test, 32'h0);
    check("test_rst_status", {29'h0, t_as}, 32'h0);
    transact("ill011", 3'b011, 32'hFFFF_FFFF);
    check("ill011_status", {29'h0, t_as}, 32'h0);
    check("ill011_data", t_ad, 32'h0);
    transact("seedi", c_seed, 32'h0000_0001);
    transact("ill111", 3'b111, 32'h0);
    check("ill111_status", {29'h0, t_as}, 32'h4);
    check("ill111_data", t_ad, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
